prio_intr_ctrl: RTL and testbench
=================================

Name: prio_intr_ctrl

Overview:
Parametrised, registered successor to the combinational grouped priority-interrupt decoder. It accepts NUM_GRP buses of NUM_CH request lines, each bus with its own enable, plus a per-channel mask. Requests are latched as pending and arbitrated by fixed priority. A valid/ready handshake delivers the winning group and channel to the service agent, and an end-of-interrupt (EOI) step completes each service. It sits between raw peripheral request lines and the core's interrupt-entry logic.

Parameters:
NUM_GRP, 3, number of request buses; group 0 has the highest priority.
NUM_CH, 9, channels per bus; within a bus, channel 0 has the highest priority.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
irq_in  in  NUM_GRP*NUM_CH  raw requests; bit index g*NUM_CH+c.
grp_en  in  NUM_GRP  per-bus enable; a disabled bus is not eligible.
mask_wr  in  1  load mask_data into the mask register.
mask_data  in  NUM_GRP*NUM_CH  1 = channel masked.
irq_valid  out  1  winner offered.
irq_ready  in  1  consumer accepts the offer.
irq_grp  out  GW  winning group, GW = max(1, clog2(NUM_GRP)).
irq_ch  out  CW  winning channel, CW = max(1, clog2(NUM_CH)).
grp_active  out  NUM_GRP  registered OR of the eligible bits of each bus.
eoi  in  1  end of service.
busy  out  1  in SERVICE state.

Behaviour:
Reset:
- Clears pending, mask, the irq_in sample register, grp_active, irq_valid, irq_grp, irq_ch and busy.
- FSM enters IDLE.
- Asserting reset in any state aborts the current operation immediately; no pending bits survive.

Pending:
- A bit sets on a rising edge of irq_in, detected with a one-flop sample register.
- It clears only when that channel's offer is accepted.
- If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Masked channels and disabled buses still latch pending; they are only excluded from eligibility.

Eligibility and status:
- eligible = pending & ~mask & grp_en expanded per bus.
- grp_active is registered from the current eligible vector, so it lags by 1 cycle.

Winner selection:
- Lowest group with an eligible bit wins; within that group, the lowest channel wins.

FSM:
- IDLE: if any bit is eligible, register the winner into irq_grp/irq_ch, set irq_valid and go to OFFER. Latency from the irq_in edge to irq_valid is 2 cycles.
- OFFER: irq_valid, irq_grp and irq_ch stay stable until irq_ready. Mask writes, grp_en drops and higher-priority arrivals do not withdraw or change the offer. When irq_valid & irq_ready, clear the winner's pending bit, drop irq_valid, set busy and go to SERVICE.
- SERVICE: wait for eoi, then drop busy and go to IDLE. A new offer may be made no earlier than the cycle after IDLE is entered.

Other rules:
- eoi is ignored in IDLE and OFFER.
- irq_ready is ignored outside OFFER.
- mask_wr takes effect on the next cycle.
- No wrap-around or counter overflow exists in the fixed-priority build.

Optional Feature:
Macro: PRIO_INTR_RR_EN.
- Defined: each bus keeps a last-served channel pointer, reset to NUM_CH-1. Within a bus, priority rotates so the channel after the last-served one is highest, wrapping from NUM_CH-1 to 0. The pointer updates on acceptance. Group priority stays fixed.
- Undefined: fixed channel priority as above; no pointer registers are built.

Decomposition:
- Package prio_intr_pkg holds:
  - the FSM state enum {IDLE, OFFER, SERVICE};
  - clog2-derived width constants GW and CW as functions of the parameters;
  - the helper function flat_idx(g, c) = g*NUM_CH + c.
- One sub-module, prio_intr_pick: a combinational first-set finder over an NUM_CH vector with an optional rotate base. The block instantiates it per group, then applies a fixed group selection.

Test Plan:
- Reset, then pulse irq_in bit 4 (g0, c4) high with grp_en=3'b111 and mask 0 -> irq_valid=1 two cycles later, irq_grp=0, irq_ch=4. With irq_ready=1, busy=1 next cycle. With eoi, busy=0 and state returns to IDLE.
- Raise bits 22 (g2, c4) and 10 (g1, c1) in the same cycle -> first offer is g1/c1. After accept and eoi, second offer is g2/c4.
- mask_data bit 10 = 1, raise bit 10 -> grp_active[1]=0 and no irq_valid. Clear the mask -> irq_valid with g1/c1.
- In OFFER for g2/c0, raise bit 0 and hold irq_ready=0 for 5 cycles -> irq_grp/irq_ch stay 2/0 throughout.
- Raise a new edge on the offered bit in the same cycle as accept -> the bit remains pending and is re-offered after eoi.
- Assert rst_n=0 during SERVICE -> busy, irq_valid, pending and grp_active are all 0 immediately. With PRIO_INTR_RR_EN defined, repeatedly raise g0 bits 0 and 3 -> offers alternate c0, c3, c0.

Source files
------------

// File: rtl/prio_intr_pkg.sv
// Shared types and helpers for the grouped priority interrupt controller.
// Optional round-robin channel priority is enabled with PRIO_INTR_RR_EN.
package prio_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int NUM_GRP_DEF = 3;
    localparam int NUM_CH_DEF  = 9;

    // Index width for n items, never narrower than one bit.
    function automatic int calc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int flat_idx(input int g, input int c, input int nch = NUM_CH_DEF);
        return g * nch + c;
    endfunction

endpackage

// File: rtl/prio_intr_pick.sv
// First-set finder over one request bus; i_base is the highest-priority index
// and priority decreases upward from it, wrapping past N-1 to 0.
module prio_intr_pick #(
    parameter int N = 9,
    parameter int W = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_base,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    logic [N-1:0] w_rot;
    logic [W:0]   w_sum;

    // Rotating the doubled vector puts i_base at bit 0.
    assign w_rot = N'({i_req, i_req} >> i_base);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_base} + (W + 1)'(k);
                if (w_sum >= (W + 1)'(N))
                    w_sum = w_sum - (W + 1)'(N);
                o_idx = w_sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_intr_ctrl.sv
// Registered grouped priority interrupt controller with valid/ready offer and EOI.
// Define PRIO_INTR_RR_EN for rotating channel priority within each group.
module prio_intr_ctrl
    import prio_intr_pkg::*;
#(
    parameter  int NUM_GRP = 3,
    parameter  int NUM_CH  = 9,
    localparam int GW      = calc_w(NUM_GRP),
    localparam int CW      = calc_w(NUM_CH),
    localparam int NB      = NUM_GRP * NUM_CH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB-1:0]      i_irq_in,
    input  logic [NUM_GRP-1:0] i_grp_en,
    input  logic               i_mask_wr,
    input  logic [NB-1:0]      i_mask_data,
    output logic               o_irq_valid,
    input  logic               i_irq_ready,
    output logic [GW-1:0]      o_irq_grp,
    output logic [CW-1:0]      o_irq_ch,
    output logic [NUM_GRP-1:0] o_grp_active,
    input  logic               i_eoi,
    output logic               o_busy
);

    state_t               r_state;
    logic [NB-1:0]        r_irq_q;
    logic [NB-1:0]        r_pending;
    logic [NB-1:0]        r_mask;
    logic [NB-1:0]        w_rise;
    logic [NB-1:0]        w_clr;
    logic [NB-1:0]        w_elig;
    logic [NUM_GRP-1:0]   w_found;
    logic [NUM_GRP-1:0]   w_grp_any;
    logic [CW-1:0]        w_idx  [NUM_GRP];
    logic [CW-1:0]        w_base [NUM_GRP];
    logic                 w_any;
    logic                 w_accept;
    logic [GW-1:0]        w_win_grp;
    logic [CW-1:0]        w_win_ch;

    assign w_rise   = i_irq_in & ~r_irq_q;
    assign w_accept = (r_state == OFFER) && i_irq_ready;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        assign w_elig[g*NUM_CH +: NUM_CH] = r_pending[g*NUM_CH +: NUM_CH]
                                          & ~r_mask[g*NUM_CH +: NUM_CH]
                                          & {NUM_CH{i_grp_en[g]}};
        assign w_grp_any[g] = |w_elig[g*NUM_CH +: NUM_CH];

        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam int FI = flat_idx(g, c, NUM_CH);
            assign w_clr[FI] = w_accept && (o_irq_grp == GW'(g)) && (o_irq_ch == CW'(c));
        end

        prio_intr_pick #(.N(NUM_CH), .W(CW)) u_pick (
            .i_req   (w_elig[g*NUM_CH +: NUM_CH]),
            .i_base  (w_base[g]),
            .o_found (w_found[g]),
            .o_idx   (w_idx[g])
        );
    end

`ifdef PRIO_INTR_RR_EN
    logic [CW-1:0] r_ptr [NUM_GRP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GRP; g++) r_ptr[g] <= CW'(NUM_CH - 1);
        end else if (w_accept) begin
            for (int g = 0; g < NUM_GRP; g++)
                if (o_irq_grp == GW'(g)) r_ptr[g] <= o_irq_ch;
        end
    end

    always_comb begin
        for (int g = 0; g < NUM_GRP; g++)
            w_base[g] = (r_ptr[g] == CW'(NUM_CH - 1)) ? '0 : r_ptr[g] + 1'b1;
    end
`else
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) w_base[g] = '0;
    end
`endif

    // Fixed group priority: scanning downward leaves the lowest found group.
    always_comb begin
        w_any     = 1'b0;
        w_win_grp = '0;
        w_win_ch  = '0;
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            if (w_found[g]) begin
                w_any     = 1'b1;
                w_win_grp = GW'(g);
                w_win_ch  = w_idx[g];
            end
        end
    end

    // A new edge on an accepted bit overrides its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            o_grp_active <= '0;
        end else begin
            r_irq_q      <= i_irq_in;
            r_pending    <= (r_pending & ~w_clr) | w_rise;
            o_grp_active <= w_grp_any;
            if (i_mask_wr) r_mask <= i_mask_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            o_irq_valid <= 1'b0;
            o_irq_grp   <= '0;
            o_irq_ch    <= '0;
            o_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        o_irq_grp   <= w_win_grp;
                        o_irq_ch    <= w_win_ch;
                        o_irq_valid <= 1'b1;
                        r_state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (i_irq_ready) begin
                        o_irq_valid <= 1'b0;
                        o_busy      <= 1'b1;
                        r_state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (i_eoi) begin
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Directed self-checking bench for prio_intr_ctrl (default 3 groups x 9 channels).
// Rotating-priority checks are included when PRIO_INTR_RR_EN is defined.
module tb_prio_intr_ctrl;
    import prio_intr_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [26:0] irq_in;
    logic [2:0]  grp_en;
    logic        mask_wr;
    logic [26:0] mask_data;
    logic        irq_valid;
    logic        irq_ready;
    logic [1:0]  irq_grp;
    logic [3:0]  irq_ch;
    logic [2:0]  grp_active;
    logic        eoi;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    prio_intr_ctrl #(.NUM_GRP(3), .NUM_CH(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_irq_in     (irq_in),
        .i_grp_en     (grp_en),
        .i_mask_wr    (mask_wr),
        .i_mask_data  (mask_data),
        .o_irq_valid  (irq_valid),
        .i_irq_ready  (irq_ready),
        .o_irq_grp    (irq_grp),
        .o_irq_ch     (irq_ch),
        .o_grp_active (grp_active),
        .i_eoi        (eoi),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_offer(input string tag, input int g, input int c);
        check({tag, "_valid"}, 32'(irq_valid), 32'd1);
        check({tag, "_grp"}, 32'(irq_grp), 32'(g));
        check({tag, "_ch"}, 32'(irq_ch), 32'(c));
    endtask

    task automatic pulse(input int g, input int c);
        irq_in = '0;
        irq_in[flat_idx(g, c, 9)] = 1'b1;
        tick();
        irq_in = '0;
    endtask

    task automatic serve(input string tag);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check({tag, "_busy_set"}, 32'(busy), 32'd1);
        check({tag, "_valid_drop"}, 32'(irq_valid), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; grp_en = 3'b111; mask_wr = 1'b0;
        mask_data = '0; irq_ready = 1'b0; eoi = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grp_active", 32'(grp_active), 32'd0);
        check("rst_grp", 32'(irq_grp), 32'd0);
        check("rst_ch", 32'(irq_ch), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request g0/c4: two-cycle latency, handshake, EOI.
        pulse(0, 4);
        check("t1_valid_early", 32'(irq_valid), 32'd0);
        tick();
        check_offer("t1", 0, 4);
        check("t1_grp_active", 32'(grp_active), 32'b001);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("t1_eoi_in_offer", 32'(irq_valid), 32'd1);
        serve("t1");
        tick();
        check("t1_no_reoffer", 32'(irq_valid), 32'd0);

        // Group priority: g1/c1 beats g2/c4.
        irq_in = '0;
        irq_in[22] = 1'b1;
        irq_in[10] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        check_offer("t2a", 1, 1);
        serve("t2a");
        tick();
        check_offer("t2b", 2, 4);
        serve("t2b");

        // Masked channel latches but is not eligible until unmasked.
        mask_wr = 1'b1; mask_data = 27'(1) << 10;
        tick();
        mask_wr = 1'b0;
        pulse(1, 1);
        tick(); tick();
        check("t3_masked_valid", 32'(irq_valid), 32'd0);
        check("t3_masked_active", 32'(grp_active), 32'd0);
        mask_wr = 1'b1; mask_data = '0;
        tick();
        mask_wr = 1'b0;
        tick();
        check_offer("t3", 1, 1);
        check("t3_active", 32'(grp_active), 32'b010);
        serve("t3");

        // Offer stability while a higher-priority request arrives.
        pulse(2, 0);
        tick();
        check_offer("t4_start", 2, 0);
        irq_in[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_offer("t4_hold", 2, 0);
        end
        irq_in = '0;
        serve("t4");
        tick();
        check_offer("t4_next", 0, 0);
        serve("t4_next");

        // New edge on the offered bit during accept keeps it pending.
        pulse(0, 5);
        tick();
        check_offer("t5", 0, 5);
        irq_in[5] = 1'b1;
        irq_ready = 1'b1;
        tick();
        irq_in = '0;
        irq_ready = 1'b0;
        check("t5_busy", 32'(busy), 32'd1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        check_offer("t5_reoffer", 0, 5);
        serve("t5_re");

        // Disabled group latches pending; offered once re-enabled.
        grp_en = 3'b101;
        pulse(1, 2);
        tick(); tick();
        check("t6_disabled_valid", 32'(irq_valid), 32'd0);
        grp_en = 3'b111;
        tick();
        check_offer("t6", 1, 2);
        serve("t6");

        // Highest channel index across groups.
        irq_in = '0;
        irq_in[26] = 1'b1;
        irq_in[8] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        check_offer("t7a", 0, 8);
        serve("t7a");
        tick();
        check_offer("t7b", 2, 8);
        serve("t7b");

        // Reset in SERVICE clears everything immediately.
        pulse(0, 7);
        tick();
        check_offer("t8", 0, 7);
        irq_in[12] = 1'b1;
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        irq_in = '0;
        tick();
        check("t8_busy", 32'(busy), 32'd1);
        check("t8_active", 32'(grp_active), 32'b010);
        rst_n = 1'b0;
        #1;
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_valid", 32'(irq_valid), 32'd0);
        check("t8_rst_active", 32'(grp_active), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("t8_no_pending", 32'(irq_valid), 32'd0);
        check("t8_no_active", 32'(grp_active), 32'd0);

`ifdef PRIO_INTR_RR_EN
        irq_in = '0;
        irq_in[0] = 1'b1;
        irq_in[3] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        check_offer("rr1", 0, 0);
        serve("rr1");
        tick();
        check_offer("rr2", 0, 3);
        serve("rr2");
        irq_in[0] = 1'b1;
        irq_in[3] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        check_offer("rr3", 0, 0);
        serve("rr3");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
